// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: interrupt controller with fully nested priority and a two-pulse acknowledge.
// Define IRQ_PRIORITY_ROTATE_EN to make rotating priority (control bit1) available.
module irq_priority_ctrl #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               inta_n,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [7:0]         wr_data,
    output logic               int_out,
    output logic [7:0]         vector_out,
    output logic               vector_valid,
    output logic [NUM_IRQ-1:0] isr_out
);
    typedef enum logic [1:0] {IDLE, ACK1, WAIT_HI, ACK2} state_t;

    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] irq_s, irq_d, irr, isr, imr, rise, isr_set, isr_clr, spec_m;
    logic [4:0] base;
    logic [2:0] ctrl, ptr, idx, peff, eoi_idx;
    logic [3:0] win, top;
    logic spurious, inta_q, fall, acking, ack2, cmd_eoi, auto_eoi, int_nxt, rot_en, rot_bit;

    // {found, index} of the highest-priority set bit, scanning upward from pointer p
    function automatic logic [3:0] pick(input logic [NUM_IRQ-1:0] v, input logic [2:0] p);
        logic [NUM_IRQ-1:0] rot;
        logic [3:0] res;
        int j;
        rot = NUM_IRQ'({v, v} >> p);
        res = '0;
        for (int r = NUM_IRQ - 1; r >= 0; r--) begin
            j = int'(p) + r;
            if (rot[r]) res = {1'b1, 3'(j >= NUM_IRQ ? j - NUM_IRQ : j)};
        end
        return res;
    endfunction

    function automatic logic [2:0] rank(input logic [2:0] i, input logic [2:0] p);
        return (i >= p) ? i - p : 3'(int'(i) + NUM_IRQ - int'(p));
    endfunction

    function automatic logic [2:0] nxt(input logic [2:0] k);
        return (int'(k) == NUM_IRQ - 1) ? 3'd0 : k + 3'd1;
    endfunction

    // indices >= NUM_IRQ fall off the top and decode to zero
    function automatic logic [NUM_IRQ-1:0] dec(input logic [2:0] i);
        logic [7:0] t;
        t = 8'd1 << i;
        return t[NUM_IRQ-1:0];
    endfunction

`ifdef IRQ_PRIORITY_ROTATE_EN
    assign rot_bit = wr_data[1];
`else
    assign rot_bit = 1'b0;
`endif

    assign irq_s   = sync_q[SYNC_STAGES-1];
    assign isr_out = isr;

    always_comb begin
        rot_en   = ctrl[1];
        peff     = rot_en ? ptr : 3'd0;
        fall     = inta_q & ~inta_n;
        rise     = irq_s & ~irq_d;
        win      = pick(irr & ~imr, peff);
        top      = pick(isr, peff);
        int_nxt  = win[3] && (!top[3] || rank(win[2:0], peff) < rank(top[2:0], peff));
        acking   = state == IDLE && fall;
        ack2     = state == WAIT_HI && fall;
        spec_m   = dec(wr_data[2:0]);
        eoi_idx  = wr_data[7] ? top[2:0] : wr_data[2:0];
        cmd_eoi  = wr_en && wr_addr == 2'd3 && (wr_data[7] ? top[3] : wr_data[6] && |(isr & spec_m));
        auto_eoi = ack2 && ctrl[2] && !spurious;
        isr_set  = (acking && win[3]) ? dec(win[2:0]) : '0;
        isr_clr  = (cmd_eoi ? dec(eoi_idx) : '0) | (auto_eoi ? dec(idx) : '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = fall ? ACK1 : IDLE;
            ACK1:    state_nxt = WAIT_HI;
            WAIT_HI: state_nxt = fall ? ACK2 : WAIT_HI;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            sync_q       <= '0;
            irq_d        <= '0;
            irr          <= '0;
            isr          <= '0;
            imr          <= '1;
            base         <= '0;
            ctrl         <= '0;
            ptr          <= '0;
            idx          <= '0;
            spurious     <= 1'b0;
            inta_q       <= 1'b1;
            int_out      <= 1'b0;
            vector_out   <= '0;
            vector_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], irq_in};
            irq_d        <= irq_s;
            inta_q       <= inta_n;
            irr          <= ctrl[0] ? irq_s : (irr & ~isr_set) | rise;
            isr          <= (isr | isr_set) & ~isr_clr;
            int_out      <= state == IDLE && !fall && int_nxt;
            vector_valid <= ack2;
            if (acking) begin
                idx      <= win[2:0];
                spurious <= !win[3];
            end
            if (ack2) vector_out <= {base, spurious ? 3'd7 : idx};
            if (rot_en && cmd_eoi) ptr <= nxt(eoi_idx);
            else if (rot_en && auto_eoi) ptr <= nxt(idx);
            if (wr_en) begin
                case (wr_addr)
                    2'd0:    imr  <= wr_data[NUM_IRQ-1:0];
                    2'd1:    base <= wr_data[7:3];
                    2'd2:    ctrl <= {wr_data[2], rot_bit, wr_data[0]};
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb_irq_priority_ctrl: directed stimulus checked every cycle against a behavioural
// priority-controller model, plus literal expectations for the key scenarios.
module tb_irq_priority_ctrl;
    localparam int N = 8;
    localparam int SYNC = 2;
`ifdef IRQ_PRIORITY_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0, inta_n = 1'b1, wr_en = 1'b0;
    logic [N-1:0] irq_in = '0;
    logic [1:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic int_out, vector_valid;
    logic [7:0] vector_out;
    logic [N-1:0] isr_out;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    irq_priority_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset_n(reset_n), .irq_in(irq_in), .inta_n(inta_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .int_out(int_out),
        .vector_out(vector_out), .vector_valid(vector_valid), .isr_out(isr_out)
    );

    // behavioural model: pending/in-service flags, priority by distance from pointer
    bit pend[N], insvc[N];
    logic [N-1:0] samp[$];
    logic [N-1:0] m_mask, m_prev_s;
    logic [7:0] m_base, m_vec;
    bit m_level, m_rot, m_auto, m_prev_inta, m_int, m_vv;
    int m_ptr, m_phase, m_frozen;

    function automatic int prio(int i);
        return (i - (m_rot ? m_ptr : 0) + N) % N;
    endfunction

    function automatic int best(input bit v[N]);
        int b = -1;
        for (int i = 0; i < N; i++) if (v[i] && (b < 0 || prio(i) < prio(b))) b = i;
        return b;
    endfunction

    function automatic void eoi(int k);
        insvc[k] = 1'b0;
        if (m_rot) m_ptr = (k + 1) % N;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin pend[i] = 0; insvc[i] = 0; end
        samp = {};
        for (int i = 0; i < SYNC; i++) samp.push_back('0);
        m_mask = '1; m_prev_s = '0; m_base = '0; m_vec = '0;
        m_level = 0; m_rot = 0; m_auto = 0; m_prev_inta = 1; m_int = 0; m_vv = 0;
        m_ptr = 0; m_phase = 0; m_frozen = -1;
    endfunction

    function automatic void model_step();
        bit fall;
        bit cand[N];
        int w, t, k;
        logic [N-1:0] s;
        fall = m_prev_inta && !inta_n;
        s = samp[SYNC-1];
        for (int i = 0; i < N; i++) cand[i] = pend[i] && !m_mask[i];
        w = best(cand);
        t = best(insvc);
        m_int = m_phase == 0 && !fall && w >= 0 && (t < 0 || prio(w) < prio(t));
        m_vv = 0;
        for (int i = 0; i < N; i++)
            pend[i] = m_level ? s[i] : (pend[i] && !(m_phase == 0 && fall && w == i)) || (s[i] && !m_prev_s[i]);
        if (m_phase == 0) begin
            if (fall) begin
                m_frozen = w;
                if (w >= 0) insvc[w] = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1) m_phase = 2;
        else if (m_phase == 2) begin
            if (fall) begin
                m_vec = {m_base[7:3], m_frozen < 0 ? 3'd7 : 3'(m_frozen)};
                m_vv = 1;
                if (m_auto && m_frozen >= 0) eoi(m_frozen);
                m_phase = 3;
            end
        end else m_phase = 0;
        if (wr_en) begin
            if (wr_addr == 0) m_mask = wr_data[N-1:0];
            if (wr_addr == 1) m_base = wr_data;
            if (wr_addr == 2) begin m_level = wr_data[0]; m_rot = ROT && wr_data[1]; m_auto = wr_data[2]; end
            if (wr_addr == 3) begin
                if (wr_data[7]) begin
                    if (t >= 0) eoi(t);
                end else if (wr_data[6]) begin
                    k = int'(wr_data[2:0]);
                    if (k < N && insvc[k]) eoi(k);
                end
            end
        end
        m_prev_inta = inta_n;
        m_prev_s = s;
        samp.push_front(irq_in);
        void'(samp.pop_back());
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [N-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) e[i] = insvc[i];
            chk("int_out", {7'd0, int_out}, {7'd0, m_int});
            chk("vector_valid", {7'd0, vector_valid}, {7'd0, m_vv});
            chk("vector_out", vector_out, m_vec);
            chk("isr_out", isr_out, e);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic ack(output logic [7:0] vec, output logic vv);
        @(negedge clk) inta_n = 0;
        @(negedge clk) inta_n = 1;
        @(negedge clk) inta_n = 0;
        @(negedge clk);
        vv = vector_valid;
        vec = vector_out;
        inta_n = 1;
        tick(2);
    endtask

    logic [7:0] v;
    logic vv;

    initial begin
        tick(3);
        chk("rst int", {7'd0, int_out}, 8'h00);
        chk("rst vec", vector_out, 8'h00);
        chk("rst isr", isr_out, 8'h00);
        reset_n = 1;
        tick(2);
        // single edge request, base 0x40
        wr(0, 8'h00); wr(1, 8'h40);
        irq_in = 8'h08;
        tick(3); chk("lat early", {7'd0, int_out}, 8'h00);
        tick(1); chk("lat 4", {7'd0, int_out}, 8'h01);
        ack(v, vv);
        chk("ir3 vec", v, 8'h43); chk("ir3 vv", {7'd0, vv}, 8'h01); chk("ir3 isr", isr_out, 8'h08);
        wr(3, 8'h80); irq_in = 0; tick(4);
        chk("eoi isr", isr_out, 8'h00);
        // simultaneous IR5 and IR2
        irq_in = 8'h24; tick(5);
        ack(v, vv); chk("ir2 first", v, 8'h42);
        chk("ir5 held", {7'd0, int_out}, 8'h00);
        wr(3, 8'h80); tick(2); chk("ir5 reassert", {7'd0, int_out}, 8'h01);
        ack(v, vv); chk("ir5 second", v, 8'h45);
        wr(3, 8'h80); irq_in = 0; tick(4);
        // nesting: IR1 in service blocks IR4
        irq_in = 8'h02; tick(5);
        ack(v, vv); chk("ir1 vec", v, 8'h41); chk("ir1 isr", isr_out, 8'h02);
        irq_in = 8'h12; tick(6); chk("nest blocked", {7'd0, int_out}, 8'h00);
        wr(3, 8'h80); tick(2); chk("nest release", {7'd0, int_out}, 8'h01);
        ack(v, vv); chk("ir4 vec", v, 8'h44);
        wr(3, 8'h80); irq_in = 0; tick(4);
        // spurious acknowledge
        ack(v, vv); chk("spurious vec", v, 8'h47); chk("spurious isr", isr_out, 8'h00);
        // mask, then specific EOI
        wr(0, 8'h08); irq_in = 8'h08; tick(6); chk("masked", {7'd0, int_out}, 8'h00);
        wr(0, 8'h00); tick(2); chk("unmasked", {7'd0, int_out}, 8'h01);
        ack(v, vv); chk("unmasked vec", v, 8'h43);
        wr(3, 8'h43); tick(1); chk("spec eoi", isr_out, 8'h00);
        irq_in = 0; tick(4);
        // level mode follows the line
        wr(2, 8'h01); irq_in = 8'h01; tick(5); chk("level hi", {7'd0, int_out}, 8'h01);
        irq_in = 0; tick(5); chk("level lo", {7'd0, int_out}, 8'h00);
        wr(2, 8'h00); tick(4);
        // auto-EOI
        wr(2, 8'h04); irq_in = 8'h20; tick(5);
        ack(v, vv); chk("aeoi vec", v, 8'h45); chk("aeoi isr", isr_out, 8'h00);
        irq_in = 0; wr(2, 8'h00); tick(4);
        // reset between ACK1 and ACK2
        irq_in = 8'h40; tick(5); chk("pre rst int", {7'd0, int_out}, 8'h01);
        @(negedge clk) inta_n = 0;
        @(negedge clk) inta_n = 1;
        @(negedge clk) reset_n = 0;
        tick(1);
        chk("mid rst int", {7'd0, int_out}, 8'h00); chk("mid rst vec", vector_out, 8'h00);
        chk("mid rst vv", {7'd0, vector_valid}, 8'h00); chk("mid rst isr", isr_out, 8'h00);
        tick(2); reset_n = 1; tick(8);
        chk("imr ones", {7'd0, int_out}, 8'h00); chk("no vv", {7'd0, vector_valid}, 8'h00);
        wr(0, 8'h00); tick(2); chk("after unmask", {7'd0, int_out}, 8'h01);
        ack(v, vv); chk("base zero vec", v, 8'h06);
        wr(3, 8'h80); irq_in = 0; tick(4);
        // rotating priority: EOI of IR2 moves IR3 to the top
        wr(1, 8'h40); wr(2, 8'h02);
        irq_in = 8'h04; tick(5);
        ack(v, vv); chk("rot ir2", v, 8'h42);
        wr(3, 8'h80); irq_in = 0; tick(4);
        irq_in = 8'h0A; tick(5);
        ack(v, vv); chk("rot order", v, ROT ? 8'h43 : 8'h41);
        wr(3, 8'h80); tick(3);
        ack(v, vv); chk("rot second", v, ROT ? 8'h41 : 8'h43);
        wr(3, 8'h80); irq_in = 0; tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/irq_priority_ctrl.md
IRQ_PRIORITY_CTRL -- requirements
Module: irq_priority_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 8, number of request channels, legal range 2..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of irq_in synchroniser flops, legal range 2..3.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port irq_in  input  NUM_IRQ  asynchronous request lines, active high.
REQ-006 SHALL have port inta_n  input  1  synchronous interrupt acknowledge, active low, two pulses per cycle.
REQ-007 SHALL have port wr_en  input  1  one-cycle register write strobe.
REQ-008 SHALL have port wr_addr  input  2  register select: 0=IMR, 1=vector base, 2=control, 3=command.
REQ-009 SHALL have port wr_data  input  8  write data.
REQ-010 SHALL have port int_out  output  1  registered interrupt request to the CPU.
REQ-011 SHALL have port vector_out  output  8  acknowledged vector, held until the next ACK2.
REQ-012 SHALL have port vector_valid  output  1  one-cycle pulse on ACK2.
REQ-013 SHALL have port isr_out  output  NUM_IRQ  in-service register, for status.

Function
REQ-014 SHALL synchronise irq_in through SYNC_STAGES flops before any use.
REQ-015 Edge mode (control bit0=0): SHALL set the IRR bit on a synchronised 0->1 transition; the bit clears only on ACK1 of that index.
REQ-016 Level mode (control bit0=1): IRR SHALL equal the synchronised level.
REQ-017 On the same cycle as an ACK1 clear, a new edge on that bit SHALL win, leaving IRR=1.
REQ-018 The winner SHALL be the highest-priority bit of IRR & ~IMR; fixed priority has index 0 highest.
REQ-019 Rotating priority (control bit1=1): after an EOI of index k, the priority pointer SHALL become (k+1) mod NUM_IRQ, which is then the highest priority.
REQ-020 int_out SHALL be registered high when a winner exists whose priority is higher than every set ISR bit (fully nested).
REQ-021 Irq_in rising edge to int_out high SHALL take SYNC_STAGES+2 cycles.
REQ-022 FSM states SHALL be IDLE, ACK1, WAIT_HI and ACK2; a falling edge of inta_n is detected against its registered previous value.
REQ-023 IDLE->ACK1 on an inta_n fall: SHALL freeze the winner index, set ISR[idx], clear IRR[idx] (edge mode), and drop int_out.
REQ-024 ACK1->WAIT_HI SHALL be unconditional; WAIT_HI->ACK2 SHALL occur on the next inta_n fall.
REQ-025 ACK2 SHALL drive vector_out={base[7:3],idx[2:0]} and pulse vector_valid; if auto-EOI (control bit2) is set, it SHALL clear ISR[idx]; the FSM then returns to IDLE.
REQ-026 Spurious acknowledge (no winner at ACK1): ISR SHALL be unchanged and vector_out={base[7:3],3'd7}.
REQ-027 Command write with bit7=1 SHALL clear the highest-priority set ISR bit (non-specific EOI); bit6=1 SHALL clear ISR[wr_data[2:0]] (specific EOI); bit7 takes precedence; EOI with ISR=0 SHALL be a no-op.
REQ-028 Register writes SHALL take effect the next cycle and SHALL NOT alter a winner frozen by ACK1.
REQ-029 IMR bits at index NUM_IRQ and above SHALL be ignored; a specific EOI index >= NUM_IRQ SHALL be a no-op.

Reset
REQ-030 reset_n low SHALL asynchronously force IMR=all ones, base=0, control=0, IRR=0, ISR=0, synchronisers=0, priority pointer=0, inta_n previous=1, FSM=IDLE, int_out=0, vector_out=0, vector_valid=0.
REQ-031 Reset asserted mid-acknowledge SHALL abandon the cycle; no vector_valid pulse follows.

Configuration
REQ-032 Macro IRQ_PRIORITY_ROTATE_EN defined: rotating priority per REQ-019 is available.
REQ-033 Macro IRQ_PRIORITY_ROTATE_EN undefined: control bit1 is ignored, the pointer is held at 0, and priority is fixed.

Verification
REQ-034 IMR=0x00, base=0x40, edge mode, irq_in[3] rises -> int_out high after 4 cycles; two inta_n pulses -> vector_out=0x43, vector_valid pulse, isr_out=0x08.
REQ-035 irq_in[5] and irq_in[2] rise together -> vector 0x42 first; non-specific EOI -> int_out reasserts; second acknowledge -> vector 0x45.
REQ-036 ISR=0x02 (IR1 in service), irq_in[4] rises -> int_out stays low until EOI, then asserts.
REQ-037 Rotate on, EOI of IR2, then irq_in[1] and irq_in[3] pending -> vector base|3 served first.
REQ-038 Two inta_n pulses with no request -> vector_out=base|7, isr_out unchanged.
REQ-039 reset_n low between ACK1 and ACK2 -> all outputs 0, no vector_valid pulse, IMR reads back as all ones.
